bist_engine: RTL
================

BIST_ENGINE -- requirements
Module: bist_engine

Interface
REQ-001 The module SHALL have parameter IN_W, default 4, giving the number of functional request channels driven to the UUT.
REQ-002 The module SHALL have parameter OUT_W, default 4, giving the UUT functional response (grant) width.
REQ-003 The module SHALL have parameter LFSR_W, default 16, giving the pattern-generator width.
REQ-004 The module SHALL have parameters LFSR_POLY, default 16'hB400, and LFSR_SEED, default 16'h0001, giving the LFSR Galois feedback mask and its init value.
REQ-005 The module SHALL have parameters SIG_W, default 16, and MISR_POLY, default 16'hB400, giving the signature width and the MISR feedback mask.
REQ-006 The module SHALL have parameter CHAIN_LEN, default 8, giving the UUT scan-chain length in flops.
REQ-007 The module SHALL have parameter NUM_PATTERNS, default 256, giving the number of capture patterns per run.
REQ-008 The module SHALL have parameter SIGNATURE_VALID, default 16'h6BD2, giving the golden signature.
REQ-009 The module SHALL have port clock, input, 1 bit: the single clock, with all state on its rising edge.
REQ-010 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-011 The module SHALL have port bist_start, input, 1 bit: level-sampled request to start a run.
REQ-012 The module SHALL have ports func_i (input, IN_W bits) and func_o (output, IN_W bits): mission requests and the requests muxed into the UUT.
REQ-013 The module SHALL have port resp_i, input, OUT_W bits: UUT functional response.
REQ-014 The module SHALL have ports scan_en_o (output, 1 bit), scan_o (output, 1 bit, to UUT scan-in) and scan_i (input, 1 bit, from UUT scan-out).
REQ-015 The module SHALL have port uut_init_o, output, 1 bit: UUT reset pulse, ORed externally with reset.
REQ-016 The module SHALL have ports running_o, bist_end and pass_fail (outputs, 1 bit each), and signature_out (output, SIG_W bits).

Function
REQ-017 The module SHALL fail elaboration if IN_W>LFSR_W, OUT_W>SIG_W, CHAIN_LEN<1 or NUM_PATTERNS<1.
REQ-018 The FSM SHALL use states IDLE, INIT, SHIFT, CAPTURE, UNLOAD and DONE.
REQ-019 IDLE SHALL go to INIT when bist_start=1; INIT SHALL last 1 cycle and then go to SHIFT.
REQ-020 SHIFT SHALL last CHAIN_LEN cycles and then go to CAPTURE.
REQ-021 CAPTURE SHALL last 1 cycle and then go to SHIFT, or to UNLOAD when it is the NUM_PATTERNS-th capture.
REQ-022 UNLOAD SHALL last CHAIN_LEN cycles and then go to DONE.
REQ-023 DONE SHALL go to IDLE only when bist_start=0.
REQ-024 INIT SHALL load the LFSR with LFSR_SEED (forced to 1 if LFSR_SEED is 0), clear the MISR, clear the pattern and shift counters, and drive uut_init_o=1.
REQ-025 Each cycle in SHIFT, CAPTURE and UNLOAD, the LFSR SHALL advance as next=(l<<1)^(l[LFSR_W-1]?LFSR_POLY:0).
REQ-026 In SHIFT and UNLOAD, scan_o SHALL equal the LFSR MSB and scan_en_o SHALL be 1.
REQ-027 In SHIFT and UNLOAD, the MISR SHALL update as next=(s<<1)^(s[SIG_W-1]?MISR_POLY:0)^{0..,scan_i}.
REQ-028 In CAPTURE, scan_en_o SHALL be 0 and the MISR SHALL update with the same rule using zero-extended resp_i.
REQ-029 func_o SHALL equal the LFSR low IN_W bits while running_o=1, and SHALL equal func_i combinationally otherwise.
REQ-030 running_o SHALL be 1 in the states INIT through UNLOAD.
REQ-031 bist_end SHALL be 1 only in DONE.
REQ-032 pass_fail SHALL equal bist_end AND (MISR==SIGNATURE_VALID).
REQ-033 The MISR and LFSR SHALL hold their values in IDLE and DONE.
REQ-034 bist_start asserted while running_o=1 SHALL be ignored.
REQ-035 The pattern counter SHALL be $clog2(NUM_PATTERNS+1) bits wide and SHALL NOT wrap.
REQ-036 Run length from the cycle bist_start is sampled in IDLE to DONE entry SHALL be 1+NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN cycles.

Reset
REQ-037 reset=1 at a clock edge SHALL force IDLE, clear the LFSR, MISR and counters, and drive scan_en_o, scan_o, uut_init_o, running_o, bist_end and pass_fail to 0.
REQ-038 reset SHALL override any state, including mid-SHIFT, with IDLE in effect on the next cycle.

Configuration
REQ-039 When BIST_SIG_OUT_EN is defined, signature_out SHALL drive the live MISR value.
REQ-040 When BIST_SIG_OUT_EN is undefined, signature_out SHALL be constant 0 and pass_fail SHALL be unaffected.

Verification
REQ-041 Reset held for 2 cycles -> bist_end=0, pass_fail=0, scan_en_o=0, running_o=0, func_o==func_i.
REQ-042 CHAIN_LEN=4, NUM_PATTERNS=2, one start -> scan_en_o high for 4+4+4 cycles, 2 capture cycles, bist_end rises exactly 15 cycles after start is sampled.
REQ-043 Fault-free UUT model with golden set to its computed signature -> pass_fail=1 in DONE; flip one resp_i bit in one capture -> pass_fail=0.
REQ-044 func_i=4'hA while idle -> func_o=4'hA in the same cycle; during a run -> func_o equals the LFSR low 4 bits.
REQ-045 reset pulsed during the second SHIFT -> IDLE next cycle, all outputs 0; a new start -> bist_end after the full 15 cycles with the identical signature.
REQ-046 bist_start held high through DONE -> DONE persists; drop bist_start -> IDLE next cycle, with signature_out equal to the MISR when BIST_SIG_OUT_EN is defined and 0 otherwise.

Source files
------------

// File: rtl/bist_engine.sv
// Logic BIST controller: LFSR pattern generator, scan shift/capture sequencing and MISR compaction.
// Optional macro BIST_SIG_OUT_EN exposes the live MISR on signature_out (otherwise it is tied to 0).
module bist_engine #(
    parameter int unsigned             IN_W            = 4,
    parameter int unsigned             OUT_W           = 4,
    parameter int unsigned             LFSR_W          = 16,
    parameter logic [LFSR_W-1:0]       LFSR_POLY       = 16'hB400,
    parameter logic [LFSR_W-1:0]       LFSR_SEED       = 16'h0001,
    parameter int unsigned             SIG_W           = 16,
    parameter logic [SIG_W-1:0]        MISR_POLY       = 16'hB400,
    parameter int unsigned             CHAIN_LEN       = 8,
    parameter int unsigned             NUM_PATTERNS    = 256,
    parameter logic [SIG_W-1:0]        SIGNATURE_VALID = 16'h6BD2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bist_start,
    input  logic [IN_W-1:0]   func_i,
    output logic [IN_W-1:0]   func_o,
    input  logic [OUT_W-1:0]  resp_i,
    output logic              scan_en_o,
    output logic              scan_o,
    input  logic              scan_i,
    output logic              uut_init_o,
    output logic              running_o,
    output logic              bist_end,
    output logic              pass_fail,
    output logic [SIG_W-1:0]  signature_out
);

    if (IN_W > LFSR_W) begin : g_err_in_w
        $error("IN_W must not exceed LFSR_W");
    end
    if (OUT_W > SIG_W) begin : g_err_out_w
        $error("OUT_W must not exceed SIG_W");
    end
    if (CHAIN_LEN < 1) begin : g_err_chain
        $error("CHAIN_LEN must be at least 1");
    end
    if (NUM_PATTERNS < 1) begin : g_err_pat
        $error("NUM_PATTERNS must be at least 1");
    end

    localparam int unsigned PAT_W = $clog2(NUM_PATTERNS + 1);
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    // An all-zero seed would lock the LFSR at zero.
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StShift,
        StCapture,
        StUnload,
        StDone
    } state_t;

    state_t             state;
    logic [LFSR_W-1:0]  lfsr;
    logic [SIG_W-1:0]   misr;
    logic [CNT_W-1:0]   shift_cnt;
    logic [PAT_W-1:0]   pat_cnt;

    logic [LFSR_W-1:0]  lfsr_next;
    logic [SIG_W-1:0]   misr_shifted;
    logic               shift_last;

    assign lfsr_next    = (lfsr << 1) ^ (lfsr[LFSR_W-1] ? LFSR_POLY : '0);
    assign misr_shifted = (misr << 1) ^ (misr[SIG_W-1] ? MISR_POLY : '0);
    assign shift_last   = (shift_cnt == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            lfsr      <= '0;
            misr      <= '0;
            shift_cnt <= '0;
            pat_cnt   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (bist_start) state <= StInit;
                end
                StInit: begin
                    lfsr      <= SEED_EFF;
                    misr      <= '0;
                    shift_cnt <= '0;
                    pat_cnt   <= '0;
                    state     <= StShift;
                end
                StShift, StUnload: begin
                    lfsr <= lfsr_next;
                    misr <= misr_shifted ^ SIG_W'(scan_i);
                    if (shift_last) begin
                        shift_cnt <= '0;
                        state     <= (state == StShift) ? StCapture : StDone;
                    end else begin
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end
                StCapture: begin
                    lfsr    <= lfsr_next;
                    misr    <= misr_shifted ^ SIG_W'(resp_i);
                    pat_cnt <= pat_cnt + PAT_W'(1);
                    // pat_cnt saturates at NUM_PATTERNS because the run leaves capture here.
                    if (pat_cnt == PAT_W'(NUM_PATTERNS - 1)) state <= StUnload;
                    else state <= StShift;
                end
                StDone: begin
                    if (!bist_start) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Moore outputs decoded purely from registered state.
    assign scan_en_o  = (state == StShift) || (state == StUnload);
    assign scan_o     = scan_en_o & lfsr[LFSR_W-1];
    assign uut_init_o = (state == StInit);
    assign running_o  = (state == StInit) || (state == StShift) || (state == StCapture) ||
                        (state == StUnload);
    assign bist_end   = (state == StDone);
    assign pass_fail  = bist_end & (misr == SIGNATURE_VALID);
    assign func_o     = running_o ? lfsr[IN_W-1:0] : func_i;

`ifdef BIST_SIG_OUT_EN
    assign signature_out = misr;
`else
    assign signature_out = '0;
`endif

endmodule
